// File: rtl/sample_framer.sv
// sample_framer: queues 12-bit samples with their phase bit and frames them as SYNC/B1/B2 UART bytes.
// Define FRAME_CHECKSUM_EN to append a fourth byte C = B1 ^ B2.
module sample_framer #(
  parameter int FIFO_DEPTH = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] sample,
  input  logic        sample_valid,
  input  logic        phase,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [4:0]  fifo_level,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef FRAME_CHECKSUM_EN
  localparam logic [1:0] LAST = 2'd3;
`else
  localparam logic [1:0] LAST = 2'd2;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO} state_t;
  state_t state, state_n;
  logic [12:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [12:0] frame;
  logic [2:0] seq;
  logic [1:0] idx, idx_n;
  logic [7:0] b1, b2, byte_n;
  logic full, empty, push, pop, adv, fin;
  assign full = fifo_level == 5'(FIFO_DEPTH);
  assign empty = fifo_level == 5'd0;
  // a full FIFO still accepts a sample when the head is popped in the same cycle
  assign push = sample_valid && (!full || pop);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {phase, sample};
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + 5'(push) - 5'(pop);
      if (sample_valid && !push) overflow <= 1'b1;
    end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = empty ? IDLE : LOAD;
      LOAD:    state_n = SEND;
      SEND:    state_n = tx_busy ? SEND : WAIT_HI;
      WAIT_HI: state_n = tx_busy ? WAIT_LO : WAIT_HI;
      WAIT_LO: state_n = tx_busy ? WAIT_LO : (idx == LAST ? IDLE : SEND);
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    pop = state == LOAD;
    tx_start = state == SEND && !tx_busy;
    adv = state == WAIT_LO && !tx_busy && idx != LAST;
    fin = state == WAIT_LO && !tx_busy && idx == LAST;
  end
  assign b1 = {frame[12], seq, frame[11:8]};
  assign b2 = frame[7:0];
  assign idx_n = idx + 2'd1;
`ifdef FRAME_CHECKSUM_EN
  assign byte_n = idx_n == 2'd1 ? b1 : idx_n == 2'd2 ? b2 : b1 ^ b2;
`else
  assign byte_n = idx_n == 2'd1 ? b1 : b2;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      frame <= '0;
      seq <= '0;
      idx <= '0;
      tx_data <= '0;
    end else if (pop) begin
      frame <= mem[rd_ptr];
      idx <= '0;
      tx_data <= SYNC_BYTE;
    end else if (adv) begin
      idx <= idx_n;
      tx_data <= byte_n;
    end else if (fin) begin
      seq <= seq + 3'd1;
    end
endmodule

// File: tb/tb_sample_framer.sv
// tb_sample_framer: randomized self-checking bench for sample_framer against a frame-level byte model.
module tb_sample_framer;
`ifdef FRAME_CHECKSUM_EN
  localparam int FL = 4;
`else
  localparam int FL = 3;
`endif
  localparam int DEPTH = 8;
  localparam logic [7:0] SYNC = 8'hA5;
  logic clk = 1'b0, reset = 1'b1, sample_valid = 1'b0, phase = 1'b0, tx_busy = 1'b0;
  logic tx_start, overflow;
  logic [11:0] sample = '0;
  logic [7:0] tx_data;
  logic [4:0] fifo_level;
  int errors = 0, checks = 0, busy_cnt = 0;
  bit hold = 1'b0, rand_busy = 1'b0;
  logic [7:0] got[$], exp_q[$];
  logic [2:0] seq_m = '0;

  sample_framer #(.FIFO_DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .reset(reset), .sample(sample), .sample_valid(sample_valid), .phase(phase),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .fifo_level(fifo_level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // UART model: records each started byte, then stays busy for a while after the start edge
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      got.push_back(tx_data);
      busy_cnt = rand_busy ? int'($urandom_range(1, 12)) : 10;
    end
    @(posedge clk);
    #1;
    if (reset) busy_cnt = 0;
    tx_busy = hold || busy_cnt > 0;
    if (busy_cnt > 0) busy_cnt--;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic add_frame(input logic [11:0] s, input logic p);
    logic [7:0] b1;
    b1 = {p, seq_m, s[11:8]};
    exp_q.push_back(SYNC);
    exp_q.push_back(b1);
    exp_q.push_back(s[7:0]);
    if (FL == 4) exp_q.push_back(b1 ^ s[7:0]);
    seq_m++;
  endtask

  task automatic strobe(input logic [11:0] s, input logic p, input bit acc);
    sample = s;
    phase = p;
    sample_valid = 1'b1;
    if (acc) add_frame(s, p);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n);
    for (int i = 0; i < 3000 && got.size() < n; i++) @(negedge clk);
    chk(tag, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20000 && got.size() < exp_q.size(); i++) @(negedge clk);
    repeat (40) @(negedge clk);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic rst();
    reset = 1'b1;
    sample_valid = 1'b0;
    hold = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seq_m = '0;
    got.delete();
    exp_q.delete();
  endtask

  // send one frame and freeze the UART after its last byte starts, leaving the FSM parked in WAIT_LO
  task automatic stall_x();
    strobe(12'($urandom), 1'($urandom), 1'b1);
    wait_bytes("x_last", FL);
    hold = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n, extra;
    bit stable;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    rst();
    // latency, basic frame, stalled handshake
    sample = 12'hABC;
    phase = 1'b1;
    sample_valid = 1'b1;
    add_frame(12'hABC, 1'b1);
    @(negedge clk);
    sample_valid = 1'b0;
    chk("lat_n1", 32'(tx_start), 32'd0);
    @(negedge clk);
    chk("lat_n2", 32'(tx_start), 32'd0);
    @(negedge clk);
    chk("lat_n3", 32'(tx_start), 32'd1);
    chk("lat_data", 32'(tx_data), 32'(SYNC));
    hold = 1'b1;
    extra = 0;
    stable = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx_start) extra++;
      if (tx_data !== SYNC) stable = 1'b0;
    end
    chk("stall_no_start", 32'(extra), 32'd0);
    chk("stall_data_stable", 32'(stable), 32'd1);
    hold = 1'b0;
    drain("basic");
    // sequence wrap
    rst();
    for (int i = 0; i < 9; i++) strobe(12'h001, 1'b0, 1'b1);
    drain("seqwrap");
    // random bursts with random UART busy times
    rand_busy = 1'b1;
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) strobe(12'($urandom), 1'($urandom), 1'b1);
      drain("rand");
    end
    chk("rand_no_ovf", 32'(overflow), 32'd0);
    rand_busy = 1'b0;
    // full FIFO with push coinciding with the LOAD pop
    rst();
    stall_x();
    for (int i = 0; i < DEPTH; i++) strobe(12'($urandom), 1'($urandom), 1'b1);
    chk("full_level", 32'(fifo_level), 32'(DEPTH));
    chk("full_no_ovf", 32'(overflow), 32'd0);
    repeat (12) @(negedge clk);
    hold = 1'b0;
    repeat (3) @(negedge clk);
    chk("load_level", 32'(fifo_level), 32'(DEPTH));
    strobe(12'($urandom), 1'($urandom), 1'b1);
    chk("pushpop_level", 32'(fifo_level), 32'(DEPTH));
    chk("pushpop_ovf", 32'(overflow), 32'd0);
    drain("pushpop");
    // overflow: one sample beyond capacity is dropped
    rst();
    stall_x();
    for (int i = 0; i <= DEPTH; i++) strobe(12'($urandom), 1'($urandom), i < DEPTH);
    chk("ovf_level", 32'(fifo_level), 32'(DEPTH));
    chk("ovf_flag", 32'(overflow), 32'd1);
    repeat (12) @(negedge clk);
    hold = 1'b0;
    drain("overflow");
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_empty", 32'(fifo_level), 32'd0);
    // reset mid-frame, with a strobe during the reset cycle
    rst();
    strobe(12'h5E7, 1'b1, 1'b1);
    wait_bytes("mid_b1", 2);
    reset = 1'b1;
    sample = 12'hFFF;
    sample_valid = 1'b1;
    @(negedge clk);
    chk("mid_start", 32'(tx_start), 32'd0);
    chk("mid_data", 32'(tx_data), 32'd0);
    chk("mid_level", 32'(fifo_level), 32'd0);
    chk("mid_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    sample_valid = 1'b0;
    got.delete();
    exp_q.delete();
    seq_m = '0;
    repeat (60) @(negedge clk);
    chk("mid_no_resume", 32'(got.size()), 32'd0);
    strobe(12'h123, 1'b0, 1'b1);
    drain("fresh");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
